// File: rtl/prefetch_ctrl_pkg.sv
// Shared types for the I-cache miss path: prefetch buffer packet, controller
// states/sources and line geometry helpers.
package rv32i_types;

  localparam int LINE_OFFSET_BITS = 5;
  localparam logic [31:0] LINE_OFFSET_MASK = 32'h0000_001F;

  typedef struct packed {
    logic [31:0]  addr;
    logic [255:0] data;
    logic         available;
  } buffer_pkt_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEMAND   = 2'd1,
    PREFETCH = 2'd2,
    RESP     = 2'd3
  } pf_state_t;

  typedef enum logic {
    SRC_HIT    = 1'b0,
    SRC_DEMAND = 1'b1
  } pf_src_t;

  // Two byte addresses fall in the same 32 B line.
  function automatic logic line_match(input logic [31:0] a, input logic [31:0] b);
    return ((a ^ b) & ~LINE_OFFSET_MASK) == 32'd0;
  endfunction

  // Byte address rounded down to its line base.
  function automatic logic [31:0] line_align(input logic [31:0] a);
    return a & ~LINE_OFFSET_MASK;
  endfunction

endpackage

// File: rtl/prefetch_ctrl.sv
// Miss-path controller: serves I-cache misses from the prefetch buffer or
// memory, carries next-line prefetch reads to memory, and reports each
// completed miss so the prefetch stage can request the following line.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   IDLE     | no memory read outstanding; arbitrate demand over prefetch
//   DEMAND   | memory read for a cache miss in flight
//   PREFETCH | memory read for the prefetch stage in flight; a matching
//            | miss piggybacks on it
//   RESP     | response pulse(s) on the outputs; dfp_read ignored
//
// Response pulses are launched on the edge that enters RESP, so RESP is the
// cycle in which dfp_resp / nl_mem_resp are visible. Prefetch completion also
// passes through RESP: the requester still holds its read during the pulse
// cycle, and re-arbitrating then would reissue the same read.
module prefetch_ctrl
  import rv32i_types::*;
(
  input  logic         clk,
  input  logic         rst_n,

  input  logic [31:0]  dfp_addr,
  input  logic         dfp_read,
  output logic [255:0] dfp_rdata,
  output logic         dfp_resp,

  input  buffer_pkt_t  next_line_pkt,
  input  logic         next_line_read,
  output logic [255:0] next_line_data,
  output logic         nl_mem_resp,
  output logic         cache_miss_complete,
  output logic [31:0]  next_line_addr,

  output logic [31:0]  mem_addr,
  output logic         mem_read,
  input  logic [255:0] mem_rdata,
  input  logic         mem_resp
);

  pf_state_t    state, state_d;
  logic         piggy, piggy_d;
  logic [26:0]  served_line, served_line_d;

  logic [255:0] dfp_rdata_d;
  logic         dfp_resp_d;
  logic [255:0] next_line_data_d;
  logic         nl_mem_resp_d;
  logic         cmc_d;
  logic [31:0]  next_line_addr_d;
  logic [31:0]  mem_addr_d;
  logic         mem_read_d;

  logic         buf_hit;
  logic         pf_match;
  logic         piggy_now;

  assign buf_hit   = dfp_read && next_line_pkt.available && line_match(dfp_addr, next_line_pkt.addr);
  assign pf_match  = dfp_read && line_match(dfp_addr, mem_addr);
  assign piggy_now = piggy || pf_match;

  // Next-state, next-output and miss-completion logic.
  always_comb begin
    state_d          = state;
    piggy_d          = piggy;
    served_line_d    = served_line;
    dfp_rdata_d      = dfp_rdata;
    dfp_resp_d       = 1'b0;
    next_line_data_d = next_line_data;
    nl_mem_resp_d    = 1'b0;
    mem_addr_d       = mem_addr;
    mem_read_d       = mem_read;
    cmc_d            = dfp_resp;
    next_line_addr_d = dfp_resp ? {served_line + 27'd1, 5'b0} : next_line_addr;

    case (state)
      IDLE: begin
        if (buf_hit) begin
          dfp_rdata_d   = next_line_pkt.data;
          dfp_resp_d    = 1'b1;
          served_line_d = dfp_addr[31:LINE_OFFSET_BITS];
          state_d       = RESP;
        end else if (dfp_read) begin
          mem_addr_d    = line_align(dfp_addr);
          mem_read_d    = 1'b1;
          served_line_d = dfp_addr[31:LINE_OFFSET_BITS];
          state_d       = DEMAND;
        end else if (next_line_read && !next_line_pkt.available) begin
          mem_addr_d    = line_align(next_line_pkt.addr);
          mem_read_d    = 1'b1;
          piggy_d       = 1'b0;
          state_d       = PREFETCH;
        end
      end
      DEMAND: begin
        if (mem_resp) begin
          mem_read_d  = 1'b0;
          dfp_rdata_d = mem_rdata;
          dfp_resp_d  = 1'b1;
          state_d     = RESP;
        end
      end
      PREFETCH: begin
        if (pf_match) begin
          piggy_d       = 1'b1;
          served_line_d = dfp_addr[31:LINE_OFFSET_BITS];
        end
        if (mem_resp) begin
          mem_read_d       = 1'b0;
          next_line_data_d = mem_rdata;
          nl_mem_resp_d    = 1'b1;
          if (piggy_now) begin
            dfp_rdata_d = mem_rdata;
            dfp_resp_d  = 1'b1;
          end
          piggy_d = 1'b0;
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, bookkeeping and registered outputs; reset clears everything at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= IDLE;
      piggy               <= 1'b0;
      served_line         <= '0;
      dfp_rdata           <= '0;
      dfp_resp            <= 1'b0;
      next_line_data      <= '0;
      nl_mem_resp         <= 1'b0;
      cache_miss_complete <= 1'b0;
      next_line_addr      <= '0;
      mem_addr            <= '0;
      mem_read            <= 1'b0;
    end else begin
      state               <= state_d;
      piggy               <= piggy_d;
      served_line         <= served_line_d;
      dfp_rdata           <= dfp_rdata_d;
      dfp_resp            <= dfp_resp_d;
      next_line_data      <= next_line_data_d;
      nl_mem_resp         <= nl_mem_resp_d;
      cache_miss_complete <= cmc_d;
      next_line_addr      <= next_line_addr_d;
      mem_addr            <= mem_addr_d;
      mem_read            <= mem_read_d;
    end
  end

endmodule

// File: tb/tb_prefetch_ctrl.sv
// Directed bench for prefetch_ctrl with a fixed-latency line memory model.
module tb_prefetch_ctrl;
  import rv32i_types::*;

  localparam int MEM_LAT = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [31:0]  dfp_addr = '0;
  logic         dfp_read = 1'b0;
  logic [255:0] dfp_rdata;
  logic         dfp_resp;
  buffer_pkt_t  next_line_pkt = '0;
  logic         next_line_read = 1'b0;
  logic [255:0] next_line_data;
  logic         nl_mem_resp;
  logic         cache_miss_complete;
  logic [31:0]  next_line_addr;
  logic [31:0]  mem_addr;
  logic         mem_read;
  logic [255:0] mem_rdata;
  logic         mem_resp;

  int n_vec = 0;
  int n_err = 0;
  int mem_cnt;

  prefetch_ctrl dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .dfp_addr            (dfp_addr),
    .dfp_read            (dfp_read),
    .dfp_rdata           (dfp_rdata),
    .dfp_resp            (dfp_resp),
    .next_line_pkt       (next_line_pkt),
    .next_line_read      (next_line_read),
    .next_line_data      (next_line_data),
    .nl_mem_resp         (nl_mem_resp),
    .cache_miss_complete (cache_miss_complete),
    .next_line_addr      (next_line_addr),
    .mem_addr            (mem_addr),
    .mem_read            (mem_read),
    .mem_rdata           (mem_rdata),
    .mem_resp            (mem_resp)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] mem_line(input logic [31:0] a);
    return {8{a ^ 32'hA5A5_5A5A}};
  endfunction

  // Memory: mem_read held for MEM_LAT cycles, then a one-cycle mem_resp.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_resp  <= 1'b0;
      mem_rdata <= '0;
      mem_cnt   <= 0;
    end else if (mem_resp) begin
      mem_resp <= 1'b0;
      mem_cnt  <= 0;
    end else if (mem_read) begin
      if (mem_cnt == MEM_LAT - 2) begin
        mem_resp  <= 1'b1;
        mem_rdata <= mem_line(mem_addr);
      end else begin
        mem_cnt <= mem_cnt + 1;
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++; if (dfp_resp !== 1'b0) begin n_err++; $display("FAIL reset_dfp_resp got %0b want 0", dfp_resp); end
    n_vec++; if (dfp_rdata !== '0) begin n_err++; $display("FAIL reset_dfp_rdata got %h want 0", dfp_rdata); end
    n_vec++; if (nl_mem_resp !== 1'b0) begin n_err++; $display("FAIL reset_nl_mem_resp got %0b want 0", nl_mem_resp); end
    n_vec++; if (next_line_data !== '0) begin n_err++; $display("FAIL reset_next_line_data got %h want 0", next_line_data); end
    n_vec++; if (cache_miss_complete !== 1'b0) begin n_err++; $display("FAIL reset_cmc got %0b want 0", cache_miss_complete); end
    n_vec++; if (next_line_addr !== 32'h0) begin n_err++; $display("FAIL reset_nla got %h want 0", next_line_addr); end
    n_vec++; if (mem_addr !== 32'h0) begin n_err++; $display("FAIL reset_mem_addr got %h want 0", mem_addr); end
    n_vec++; if (mem_read !== 1'b0) begin n_err++; $display("FAIL reset_mem_read got %0b want 0", mem_read); end
  endtask

  task automatic test_hit();
    logic [255:0] d;
    d = {8{32'hC0DE_1000}} ^ {32'h1, 224'h0};
    next_line_pkt = '{addr: 32'h0000_1000, data: d, available: 1'b1};
    dfp_addr = 32'h0000_1004;
    dfp_read = 1'b1;
    @(negedge clk);
    n_vec++; if (dfp_resp !== 1'b1) begin n_err++; $display("FAIL hit_resp got %0b want 1", dfp_resp); end
    n_vec++; if (dfp_rdata !== d) begin n_err++; $display("FAIL hit_data got %h want %h", dfp_rdata, d); end
    n_vec++; if (mem_read !== 1'b0) begin n_err++; $display("FAIL hit_no_mem_read got %0b want 0", mem_read); end
    dfp_read = 1'b0;
    @(negedge clk);
    n_vec++; if (dfp_resp !== 1'b0) begin n_err++; $display("FAIL hit_resp_pulse got %0b want 0", dfp_resp); end
    n_vec++; if (cache_miss_complete !== 1'b1) begin n_err++; $display("FAIL hit_cmc got %0b want 1", cache_miss_complete); end
    n_vec++; if (next_line_addr !== 32'h0000_1020) begin n_err++; $display("FAIL hit_nla got %h want 00001020", next_line_addr); end
    n_vec++; if (mem_read !== 1'b0) begin n_err++; $display("FAIL hit_no_mem_read2 got %0b want 0", mem_read); end
  endtask

  task automatic test_demand();
    int hi = 0;
    logic [31:0] addr_seen = '0;
    logic resp_prev = 1'b0;
    next_line_pkt = '{addr: 32'h0000_9000, data: '1, available: 1'b0};
    dfp_addr = 32'h0000_2010;
    dfp_read = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (dfp_resp) break;
      if (mem_read) begin hi++; addr_seen = mem_addr; end
      resp_prev = mem_resp;
    end
    n_vec++; if (dfp_resp !== 1'b1) begin n_err++; $display("FAIL demand_resp_timeout got %0b want 1", dfp_resp); end
    n_vec++; if (hi != MEM_LAT) begin n_err++; $display("FAIL demand_mem_read_cycles got %0d want %0d", hi, MEM_LAT); end
    n_vec++; if (addr_seen !== 32'h0000_2000) begin n_err++; $display("FAIL demand_mem_addr got %h want 00002000", addr_seen); end
    n_vec++; if (resp_prev !== 1'b1) begin n_err++; $display("FAIL demand_resp_after_mem_resp got %0b want 1", resp_prev); end
    n_vec++; if (dfp_rdata !== mem_line(32'h0000_2000)) begin n_err++; $display("FAIL demand_data got %h want %h", dfp_rdata, mem_line(32'h0000_2000)); end
    dfp_read = 1'b0;
    @(negedge clk);
    n_vec++; if (cache_miss_complete !== 1'b1) begin n_err++; $display("FAIL demand_cmc got %0b want 1", cache_miss_complete); end
    n_vec++; if (next_line_addr !== 32'h0000_2020) begin n_err++; $display("FAIL demand_nla got %h want 00002020", next_line_addr); end
    @(negedge clk);
    n_vec++; if (cache_miss_complete !== 1'b0) begin n_err++; $display("FAIL demand_cmc_pulse got %0b want 0", cache_miss_complete); end
    n_vec++; if (next_line_addr !== 32'h0000_2020) begin n_err++; $display("FAIL demand_nla_hold got %h want 00002020", next_line_addr); end
  endtask

  task automatic test_priority();
    next_line_pkt = '{addr: 32'h0000_5000, data: '0, available: 1'b0};
    dfp_addr = 32'h0000_4000;
    dfp_read = 1'b1;
    next_line_read = 1'b1;
    @(negedge clk);
    n_vec++; if (mem_addr !== 32'h0000_4000) begin n_err++; $display("FAIL prio_first_addr got %h want 00004000", mem_addr); end
    for (int i = 0; i < 30 && !dfp_resp; i++) @(negedge clk);
    n_vec++; if (dfp_resp !== 1'b1) begin n_err++; $display("FAIL prio_demand_timeout got %0b want 1", dfp_resp); end
    n_vec++; if (dfp_rdata !== mem_line(32'h0000_4000)) begin n_err++; $display("FAIL prio_demand_data got %h want %h", dfp_rdata, mem_line(32'h0000_4000)); end
    dfp_read = 1'b0;
    @(negedge clk);
    n_vec++; if (mem_read !== 1'b0) begin n_err++; $display("FAIL prio_idle_gap got %0b want 0", mem_read); end
    n_vec++; if (next_line_addr !== 32'h0000_4020) begin n_err++; $display("FAIL prio_nla got %h want 00004020", next_line_addr); end
    @(negedge clk);
    n_vec++; if (mem_read !== 1'b1) begin n_err++; $display("FAIL prio_pf_start got %0b want 1", mem_read); end
    n_vec++; if (mem_addr !== 32'h0000_5000) begin n_err++; $display("FAIL prio_pf_addr got %h want 00005000", mem_addr); end
    for (int i = 0; i < 30 && !nl_mem_resp; i++) @(negedge clk);
    n_vec++; if (nl_mem_resp !== 1'b1) begin n_err++; $display("FAIL prio_pf_timeout got %0b want 1", nl_mem_resp); end
    n_vec++; if (next_line_data !== mem_line(32'h0000_5000)) begin n_err++; $display("FAIL prio_pf_data got %h want %h", next_line_data, mem_line(32'h0000_5000)); end
    n_vec++; if (dfp_resp !== 1'b0) begin n_err++; $display("FAIL prio_pf_no_dfp got %0b want 0", dfp_resp); end
    next_line_read = 1'b0;
    @(negedge clk);
    n_vec++; if (cache_miss_complete !== 1'b0) begin n_err++; $display("FAIL prio_pf_no_cmc got %0b want 0", cache_miss_complete); end
    n_vec++; if (mem_read !== 1'b0) begin n_err++; $display("FAIL prio_pf_done got %0b want 0", mem_read); end
  endtask

  task automatic test_piggyback();
    int rises = 0;
    logic prev_rd = 1'b1;
    next_line_pkt = '{addr: 32'h0000_3020, data: '0, available: 1'b0};
    next_line_read = 1'b1;
    @(negedge clk);
    n_vec++; if (mem_addr !== 32'h0000_3020 || mem_read !== 1'b1) begin n_err++; $display("FAIL piggy_pf_issue got %h/%0b want 00003020/1", mem_addr, mem_read); end
    dfp_addr = 32'h0000_3024;
    dfp_read = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (mem_read && !prev_rd) rises++;
      prev_rd = mem_read;
      if (nl_mem_resp) break;
    end
    n_vec++; if (nl_mem_resp !== 1'b1) begin n_err++; $display("FAIL piggy_nl_timeout got %0b want 1", nl_mem_resp); end
    n_vec++; if (rises != 0) begin n_err++; $display("FAIL piggy_second_read got %0d want 0", rises); end
    n_vec++; if (dfp_resp !== 1'b1) begin n_err++; $display("FAIL piggy_dfp_same_cycle got %0b want 1", dfp_resp); end
    n_vec++; if (dfp_rdata !== mem_line(32'h0000_3020)) begin n_err++; $display("FAIL piggy_dfp_data got %h want %h", dfp_rdata, mem_line(32'h0000_3020)); end
    n_vec++; if (next_line_data !== mem_line(32'h0000_3020)) begin n_err++; $display("FAIL piggy_nl_data got %h want %h", next_line_data, mem_line(32'h0000_3020)); end
    dfp_read = 1'b0;
    next_line_read = 1'b0;
    @(negedge clk);
    n_vec++; if (cache_miss_complete !== 1'b1) begin n_err++; $display("FAIL piggy_cmc got %0b want 1", cache_miss_complete); end
    n_vec++; if (nl_mem_resp !== 1'b0) begin n_err++; $display("FAIL piggy_cmc_vs_nl got %0b want 0", nl_mem_resp); end
    n_vec++; if (next_line_addr !== 32'h0000_3040) begin n_err++; $display("FAIL piggy_nla got %h want 00003040", next_line_addr); end
    @(negedge clk);
    n_vec++; if (mem_read !== 1'b0 || dfp_resp !== 1'b0) begin n_err++; $display("FAIL piggy_idle got %0b/%0b want 0/0", mem_read, dfp_resp); end
  endtask

  task automatic test_wrap();
    next_line_pkt = '{addr: 32'h0000_0000, data: '0, available: 1'b0};
    dfp_addr = 32'hFFFF_FFE4;
    dfp_read = 1'b1;
    for (int i = 0; i < 30 && !dfp_resp; i++) @(negedge clk);
    n_vec++; if (dfp_resp !== 1'b1) begin n_err++; $display("FAIL wrap_timeout got %0b want 1", dfp_resp); end
    n_vec++; if (dfp_rdata !== mem_line(32'hFFFF_FFE0)) begin n_err++; $display("FAIL wrap_data got %h want %h", dfp_rdata, mem_line(32'hFFFF_FFE0)); end
    dfp_read = 1'b0;
    @(negedge clk);
    n_vec++; if (cache_miss_complete !== 1'b1) begin n_err++; $display("FAIL wrap_cmc got %0b want 1", cache_miss_complete); end
    n_vec++; if (next_line_addr !== 32'h0000_0000) begin n_err++; $display("FAIL wrap_nla got %h want 00000000", next_line_addr); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [255:0] d;
    d = {8{32'h7777_0000}};
    next_line_pkt = '{addr: 32'h0000_7000, data: d, available: 1'b1};
    dfp_addr = 32'h0000_7000;
    dfp_read = 1'b1;
    @(negedge clk);
    dfp_read = 1'b0;
    @(negedge clk);
    n_vec++; if (next_line_addr !== 32'h0000_7020) begin n_err++; $display("FAIL rstmid_pre_nla got %h want 00007020", next_line_addr); end
    next_line_pkt.available = 1'b0;
    dfp_addr = 32'h0000_6000;
    dfp_read = 1'b1;
    @(negedge clk);
    n_vec++; if (mem_read !== 1'b1) begin n_err++; $display("FAIL rstmid_demand got %0b want 1", mem_read); end
    rst_n = 1'b0;
    #1;
    n_vec++; if (mem_read !== 1'b0) begin n_err++; $display("FAIL rstmid_mem_read got %0b want 0", mem_read); end
    n_vec++; if (mem_addr !== 32'h0) begin n_err++; $display("FAIL rstmid_mem_addr got %h want 0", mem_addr); end
    n_vec++; if (next_line_addr !== 32'h0) begin n_err++; $display("FAIL rstmid_nla got %h want 0", next_line_addr); end
    n_vec++; if (dfp_rdata !== '0) begin n_err++; $display("FAIL rstmid_dfp_rdata got %h want 0", dfp_rdata); end
    dfp_read = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      n_vec++; if (mem_read !== 1'b0 || dfp_resp !== 1'b0) begin n_err++; $display("FAIL rstmid_quiet got %0b/%0b want 0/0", mem_read, dfp_resp); end
    end
    next_line_pkt.available = 1'b1;
    dfp_addr = 32'h0000_7008;
    dfp_read = 1'b1;
    @(negedge clk);
    n_vec++; if (dfp_resp !== 1'b1 || dfp_rdata !== d) begin n_err++; $display("FAIL rstmid_idle_hit got %0b/%h want 1/%h", dfp_resp, dfp_rdata, d); end
    dfp_read = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_hit();
    test_demand();
    test_priority();
    test_piggyback();
    test_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
